// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: constants shared by the FIFO stream reader
package fifo_stream_reader_pkg;
  localparam int unsigned BUF_DEPTH = 2;
endpackage

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a show-ahead FIFO into a registered valid/ready stream via a 2-entry buffer
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_rd_en_o,
  input  logic             flush_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic [1:0]       level_o
);
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic pop, acc;
  assign m_valid_o = cnt_q != '0;
  assign m_data_o  = head_q;
  assign level_o   = cnt_q;
  // pop request depends only on registered occupancy and FIFO flags, never on m_ready_i
  always_comb begin
    fifo_rd_en_o = !rst_i && !fifo_empty_i && (cnt_q < FULL || flush_i);
    pop = fifo_rd_en_o && !flush_i;
    acc = m_valid_o && m_ready_i && !flush_i;
  end
  // next state: new word lands in head if head is free or leaving, else in skid; skid shifts up on accept when full
  always_comb begin
    cnt_d  = flush_i ? '0 : cnt_q + CNT_W'(pop) - CNT_W'(acc);
    head_d = (pop && (cnt_q == '0 || acc)) ? fifo_data_i : (acc && cnt_q == FULL) ? skid_q : head_q;
    skid_d = (pop && cnt_q != '0 && !acc) ? fifo_data_i : skid_q;
  end
  // buffer registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized and directed check of the stream reader against a queue model
module tb_fifo_stream_reader;
  logic       clk_i = 0;
  logic       rst_i = 1;
  logic       fifo_empty_i = 1;
  logic [9:0] fifo_data_i = '0;
  logic       fifo_rd_en_o;
  logic       flush_i = 0;
  logic       m_valid_o;
  logic       m_ready_i = 0;
  logic [9:0] m_data_o;
  logic [1:0] level_o;
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  bit armed = 0;
  logic [9:0] fq[$];
  logic [9:0] mb[$];

  fifo_stream_reader #(.WIDTH(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_rd_en_o(fifo_rd_en_o), .flush_i(flush_i), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_data_o(m_data_o), .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit wr, input logic [9:0] wd, input bit rdy, input bit fl, input bit rs);
    bit exp_rd;
    @(negedge clk_i);
    m_ready_i = rdy;
    flush_i = fl;
    rst_i = rs;
    fifo_empty_i = fq.size() == 0;
    fifo_data_i = fq.size() != 0 ? fq[0] : '0;
    #1;
    exp_rd = !rs && fq.size() != 0 && (mb.size() < 2 || fl);
    chk("rd_en", {31'd0, fifo_rd_en_o}, {31'd0, exp_rd});
    if (fifo_rd_en_o === 1'b1) rd_cnt++;
    if (armed) begin
      chk("m_valid", {31'd0, m_valid_o}, {31'd0, mb.size() != 0});
      chk("level", {30'd0, level_o}, mb.size());
      if (mb.size() != 0) chk("m_data", {22'd0, m_data_o}, {22'd0, mb[0]});
    end
    @(posedge clk_i);
    if (rs) begin
      mb.delete();
      fq.delete();
      armed = 1;
    end else begin
      if (fl) begin
        mb.delete();
        if (exp_rd) void'(fq.pop_front());
      end else begin
        if (mb.size() != 0 && rdy) void'(mb.pop_front());
        if (exp_rd) mb.push_back(fq.pop_front());
      end
      if (wr) fq.push_back(wd);
    end
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("reset_data", {22'd0, m_data_o}, 32'd0);
    chk("reset_level", {30'd0, level_o}, 32'd0);
    rd_cnt = 0;
    for (int i = 1; i <= 4; i++) step(1, 10'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    chk("stream_pops", rd_cnt, 4);
    rd_cnt = 0;
    step(1, 10'h00A, 0, 0, 0);
    step(1, 10'h00B, 0, 0, 0);
    step(1, 10'h00C, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    chk("stall_pops", rd_cnt, 2);
    chk("stall_level", {30'd0, level_o}, 32'd2);
    chk("stall_head", {22'd0, m_data_o}, 32'h00A);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 10'(10'h010 + i), i[0] == 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, i[0] == 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 10'(10'h020 + i), 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
    chk("flush_valid", {31'd0, m_valid_o}, 32'd0);
    chk("flush_empty", {31'd0, fifo_rd_en_o}, 32'd0);
    step(1, 10'h3FF, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 10'(10'h030 + i), 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("rst_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_level", {30'd0, level_o}, 32'd0);
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
    chk("idle_pops", rd_cnt, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 1) == 1, 10'($urandom_range(0, 1023)), $urandom_range(0, 9) < 6,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
